// File: rtl/sniff_fault_ctrl_if.sv
// Tap, register-port and fault-control signals shared between
// the sniffer fault controller and whoever drives it.
interface sniff_fault_ctrl_if;
   logic       cfg_we_i;
   logic [1:0] cfg_addr_i;
   logic [7:0] cfg_wdata_i;
   logic [7:0] cfg_rdata_o;
   logic       serial_in_i;
   logic       start_i;
   logic       enable_i;
   logic       flip_o;
   logic       match_o;
   logic       busy_o;

   modport slave (
      input  cfg_we_i,
      input  cfg_addr_i,
      input  cfg_wdata_i,
      output cfg_rdata_o,
      input  serial_in_i,
      input  start_i,
      input  enable_i,
      output flip_o,
      output match_o,
      output busy_o
   );

   modport master (
      output cfg_we_i,
      output cfg_addr_i,
      output cfg_wdata_i,
      input  cfg_rdata_o,
      output serial_in_i,
      output start_i,
      output enable_i,
      input  flip_o,
      input  match_o,
      input  busy_o
   );
endinterface

// File: rtl/sniff_fault_ctrl.sv
// Sniffer fault controller: matches MSB-first nibbles on the tapped
// line against PATTERN and flips the following NUM_ERR enabled bits.
module sniff_fault_ctrl #(
   parameter int PAT_W = 4,
   parameter int ERR_W = 2,
   parameter int SAT_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   sniff_fault_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_INJECT = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           r_state;
   logic             r_en;
   logic [PAT_W-1:0] r_pattern;
   logic [ERR_W-1:0] r_num_err;
   logic [ERR_W-1:0] r_burst;
   logic [3:0]       r_match_cnt;
   logic [SAT_W-1:0] r_flip_cnt;
   logic [PAT_W-2:0] r_sr;
   logic [1:0]       r_bit_cnt;
   logic             r_match;

   logic             w_wr_ctrl;
   logic             w_clr;
   logic             w_dis;
   logic [PAT_W-1:0] w_nibble;
   logic [7:0]       w_rdata;
   logic             w_unused;

   assign w_wr_ctrl = bus.cfg_we_i && (bus.cfg_addr_i == 2'd0);
   assign w_clr     = w_wr_ctrl && bus.cfg_wdata_i[1];
   assign w_dis     = w_wr_ctrl && !bus.cfg_wdata_i[0];
   assign w_nibble  = {r_sr, bus.serial_in_i};
   assign w_unused  = ^bus.cfg_wdata_i[7:PAT_W];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_en        <= 1'b1;
         r_pattern   <= PAT_W'(4'h7);
         r_num_err   <= ERR_W'(1);
         r_burst     <= '0;
         r_match_cnt <= '0;
         r_flip_cnt  <= '0;
         r_sr        <= '0;
         r_bit_cnt   <= '0;
         r_match     <= 1'b0;
      end else begin
         r_match <= 1'b0;

         if (bus.cfg_we_i) begin
            unique case (bus.cfg_addr_i)
               2'd0:    r_en      <= bus.cfg_wdata_i[0];
               2'd1:    r_pattern <= bus.cfg_wdata_i[PAT_W-1:0];
               2'd2:    r_num_err <= bus.cfg_wdata_i[ERR_W-1:0];
               default: ;
            endcase
         end

         // a disabling write beats a restart in the same cycle
         if (w_dis) begin
            r_state <= S_IDLE;
         end else if (bus.start_i && (r_en || r_state != S_IDLE)) begin
            r_state   <= S_SHIFT;
            r_sr      <= '0;
            r_bit_cnt <= '0;
         end else if (r_state != S_IDLE) begin
            if (!bus.enable_i) begin
               r_state <= S_IDLE;
            end else begin
               r_sr      <= w_nibble[PAT_W-2:0];
               r_bit_cnt <= r_bit_cnt + 2'd1;
               unique case (r_state)
                  S_SHIFT: begin
                     if (r_bit_cnt == 2'd3 && w_nibble == r_pattern) begin
                        r_match <= 1'b1;
                        if (r_match_cnt != 4'hF)
                           r_match_cnt <= r_match_cnt + 4'd1;
                        if (r_num_err != '0) begin
                           r_state <= S_INJECT;
                           r_burst <= r_num_err;
                        end
                     end
                  end
                  S_INJECT: begin
                     r_burst <= r_burst - ERR_W'(1);
                     if (!(&r_flip_cnt))
                        r_flip_cnt <= r_flip_cnt + SAT_W'(1);
                     if (r_burst == ERR_W'(1))
                        r_state <= S_DONE;
                  end
                  default: ;
               endcase
            end
         end

         if (w_clr) begin
            r_match_cnt <= '0;
            r_flip_cnt  <= '0;
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      unique case (bus.cfg_addr_i)
         2'd0:    w_rdata = {7'd0, r_en};
         2'd1:    w_rdata = 8'(r_pattern);
         2'd2:    w_rdata = 8'(r_num_err);
         default: w_rdata = {r_match_cnt, 2'b00, r_state};
      endcase
   end

   assign bus.cfg_rdata_o = w_rdata;
   assign bus.flip_o      = (r_state == S_INJECT) && bus.enable_i && r_en;
   assign bus.match_o     = r_match;
   assign bus.busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sniff_fault_ctrl.sv
// Randomised and directed bench for sniff_fault_ctrl against a
// bit-counting frame model.
module tb_sniff_fault_ctrl;

   logic clk = 1'b0;
   logic rst;

   sniff_fault_ctrl_if bus();

   sniff_fault_ctrl dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   localparam int IDLE = 0, SHIFT = 1, INJECT = 2, DONE = 3;

   int         m_mode;
   int         m_nbits;
   int         m_nib;
   int         m_left;
   int         m_mcnt;
   int         m_nerr;
   logic [3:0] m_pat;
   bit         m_en;
   bit         m_match;

   logic       obs_flip;
   logic       obs_match;
   logic       obs_busy;
   logic [7:0] obs_rdata;

   task automatic model_reset();
      m_mode  = IDLE;
      m_nbits = 0;
      m_nib   = 0;
      m_left  = 0;
      m_mcnt  = 0;
      m_nerr  = 1;
      m_pat   = 4'h7;
      m_en    = 1'b1;
      m_match = 1'b0;
   endtask

   function automatic logic [7:0] model_rd(logic [1:0] a);
      case (a)
         2'd0:    return {7'd0, m_en};
         2'd1:    return {4'd0, m_pat};
         2'd2:    return 8'(m_nerr);
         default: return 8'(m_mcnt * 16 + m_mode);
      endcase
   endfunction

   task automatic model_update();
      bit         wr;
      logic [1:0] a;
      logic [7:0] d;
      m_match = 1'b0;
      if (rst) begin
         model_reset();
         return;
      end
      wr = bus.cfg_we_i;
      a  = bus.cfg_addr_i;
      d  = bus.cfg_wdata_i;
      if (wr && a == 2'd0 && !d[0]) begin
         m_mode = IDLE;
      end else if (bus.start_i && (m_mode != IDLE || m_en)) begin
         m_mode  = SHIFT;
         m_nbits = 0;
         m_nib   = 0;
      end else if (m_mode != IDLE) begin
         if (!bus.enable_i) begin
            m_mode = IDLE;
         end else begin
            m_nib = (m_nib * 2 + int'(bus.serial_in_i)) % 16;
            m_nbits++;
            if (m_mode == SHIFT && m_nbits % 4 == 0 && m_nib == int'(m_pat)) begin
               m_match = 1'b1;
               if (m_mcnt < 15) m_mcnt++;
               if (m_nerr > 0) begin
                  m_mode = INJECT;
                  m_left = m_nerr;
               end
            end else if (m_mode == INJECT) begin
               m_left--;
               if (m_left == 0) m_mode = DONE;
            end
         end
      end
      if (wr) begin
         case (a)
            2'd0: begin
               m_en = d[0];
               if (d[1]) m_mcnt = 0;
            end
            2'd1: m_pat  = d[3:0];
            2'd2: m_nerr = int'(d[1:0]);
            default: ;
         endcase
      end
   endtask

   task automatic step(bit do_chk);
      @(negedge clk);
      #1;
      obs_flip  = bus.flip_o;
      obs_match = bus.match_o;
      obs_busy  = bus.busy_o;
      obs_rdata = bus.cfg_rdata_o;
      if (do_chk) begin
         check("flip", obs_flip, (m_mode == INJECT) && bus.enable_i && m_en);
         check("match", obs_match, m_match);
         check("busy", obs_busy, m_mode != IDLE);
         check("rdata", obs_rdata, model_rd(bus.cfg_addr_i));
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus.cfg_we_i    = 1'b1;
      bus.cfg_addr_i  = a;
      bus.cfg_wdata_i = d;
      bus.enable_i    = 1'b0;
      step(1);
      bus.cfg_we_i    = 1'b0;
      bus.cfg_addr_i  = 2'd3;
   endtask

   task automatic frame(input logic [7:0] bits, input int n,
                        output logic [7:0] fm, output logic [7:0] mm);
      fm = '0;
      mm = '0;
      bus.start_i  = 1'b1;
      bus.enable_i = 1'b0;
      step(1);
      bus.start_i  = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.enable_i    = 1'b1;
         bus.serial_in_i = bits[n-1-i];
         step(1);
         fm[i] = obs_flip;
         mm[i] = obs_match;
      end
   endtask

   task automatic idle_read();
      bus.enable_i   = 1'b0;
      bus.cfg_addr_i = 2'd3;
      step(1);
   endtask

   logic [7:0] fm, mm;

   initial begin
      model_reset();
      rst             = 1'b1;
      bus.cfg_we_i    = 1'b0;
      bus.cfg_addr_i  = 2'd3;
      bus.cfg_wdata_i = '0;
      bus.serial_in_i = 1'b0;
      bus.start_i     = 1'b0;
      bus.enable_i    = 1'b0;
      step(0);
      step(0);
      rst = 1'b0;

      for (int a = 0; a < 4; a++) begin
         bus.cfg_addr_i = 2'(a);
         step(1);
         case (a)
            0: check("rst_ctrl", obs_rdata, 8'h01);
            1: check("rst_pat", obs_rdata, 8'h07);
            2: check("rst_nerr", obs_rdata, 8'h01);
            default: check("rst_status", obs_rdata, 8'h00);
         endcase
      end
      bus.cfg_addr_i = 2'd3;

      frame(8'b0111_1010, 8, fm, mm);
      check("t1_flips", fm, 8'h10);
      check("t1_match", mm, 8'h10);
      idle_read();
      check("t1_status", obs_rdata, 8'h13);

      wr(2'd2, 8'h03);
      wr(2'd1, 8'h0A);
      frame(8'b1010_1111, 8, fm, mm);
      check("t2_flips", fm, 8'h70);
      check("t2_match", mm, 8'h10);
      idle_read();
      check("t2_status", obs_rdata, 8'h23);

      wr(2'd2, 8'h00);
      frame(8'b1010_0000, 8, fm, mm);
      check("t3_flips", fm, 8'h00);
      check("t3_match", mm, 8'h10);
      idle_read();
      check("t3_status", obs_rdata, 8'h31);

      wr(2'd2, 8'h03);
      frame(8'b0001_0101, 5, fm, mm);
      check("t4_flips", fm, 8'h10);
      bus.enable_i = 1'b0;
      step(1);
      check("t4_gap_flip", obs_flip, 1'b0);
      step(1);
      check("t4_gap_busy", obs_busy, 1'b0);
      frame(8'b0000_0010, 2, fm, mm);
      frame(8'b0000_1010, 4, fm, mm);
      bus.serial_in_i = 1'b0;
      step(1);
      check("t4_rematch", obs_match, 1'b1);
      check("t4_reflip", obs_flip, 1'b1);
      idle_read();

      frame(8'b0001_0101, 5, fm, mm);
      bus.cfg_we_i    = 1'b1;
      bus.cfg_addr_i  = 2'd0;
      bus.cfg_wdata_i = 8'h00;
      bus.enable_i    = 1'b1;
      step(1);
      check("t5_dis_same", obs_flip, 1'b1);
      bus.cfg_we_i = 1'b0;
      step(1);
      check("t5_dis_next", obs_flip, 1'b0);
      check("t5_dis_busy", obs_busy, 1'b0);
      wr(2'd0, 8'h01);

      frame(8'b0001_0101, 5, fm, mm);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(1);
      check("t6_rst_flip", obs_flip, 1'b0);
      check("t6_rst_status", obs_rdata, 8'h00);

      wr(2'd1, 8'h0A);
      wr(2'd2, 8'h00);
      for (int k = 0; k < 16; k++)
         frame(8'b0000_1010, 4, fm, mm);
      idle_read();
      check("t7_sat", obs_rdata, 8'hF1);
      wr(2'd0, 8'h03);
      idle_read();
      check("t7_clr", obs_rdata, 8'h00);

      for (int c = 0; c < 3000; c++) begin
         rst             = ($urandom_range(0, 399) == 0);
         bus.cfg_we_i    = ($urandom_range(0, 15) == 0);
         bus.cfg_addr_i  = 2'($urandom_range(0, 3));
         bus.cfg_wdata_i = 8'($urandom);
         if ($urandom_range(0, 7) != 0) bus.cfg_wdata_i[0] = 1'b1;
         bus.start_i     = ($urandom_range(0, 19) == 0);
         bus.enable_i    = ($urandom_range(0, 7) != 0);
         bus.serial_in_i = 1'($urandom);
         step(1);
      end
      rst          = 1'b0;
      bus.cfg_we_i = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
